// File: rtl/stopwatch_display_driver_if.sv
// Display-side signal bundle for stopwatch_display_driver: the scan/blink strobes,
// the adjust controls, the counts in, and the segment/anode drive out.
interface stopwatch_display_driver_if;
    logic       scan_tick;
    logic       blink_tick;
    logic       adj;
    logic       sel;
    logic [6:0] minutes_input;
    logic [5:0] seconds_input;
    logic [6:0] seg;
    logic [3:0] an;
    logic       conv_busy;

    modport master (
        output scan_tick, blink_tick, adj, sel, minutes_input, seconds_input,
        input  seg, an, conv_busy
    );

    modport slave (
        input  scan_tick, blink_tick, adj, sel, minutes_input, seconds_input,
        output seg, an, conv_busy
    );
endinterface

// File: rtl/stopwatch_display_driver.sv
// MM:SS multiplexed 7-segment driver with a per-frame snapshot and sequential shift-add-3 BCD conversion.
// Define STOPWATCH_LEADING_ZERO_BLANK_EN to blank the minutes tens digit whenever it is zero.
module stopwatch_display_driver #(
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input logic                        magic_clk,
    input logic                        reset,
    stopwatch_display_driver_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0] AN_OFF  = AN_ACTIVE_LOW  ? 4'hF  : 4'h0;

    state_t      state_q;
    logic [1:0]  digit_idx_q;
    logic        blink_phase_q;
    logic        conv_busy_q;
    logic [3:0]  an_q;
    logic [6:0]  seg_q;
    logic [2:0]  shift_cnt_q;
    logic [6:0]  snap_q [2];      // 0 = seconds, 1 = minutes
    logic [14:0] sh_q [2];        // {tens, ones, binary}
    logic [3:0]  disp_q [4];      // indexed like digit_idx: 3 = minutes tens

    logic        blink_phase_d;
    logic [6:0]  clamp_min_d;
    logic [6:0]  clamp_sec_d;
    logic [3:0]  cur_digit_d;
    logic        blank_d;
    logic [6:0]  seg_d;
    logic [3:0]  an_d;
    logic [14:0] dab_d [2];

    function automatic logic [6:0] decode(input logic [3:0] bcd);
        logic [6:0] pat;
        case (bcd)
            4'd0:    pat = 7'b0111111;
            4'd1:    pat = 7'b0000110;
            4'd2:    pat = 7'b1011011;
            4'd3:    pat = 7'b1001111;
            4'd4:    pat = 7'b1100110;
            4'd5:    pat = 7'b1101101;
            4'd6:    pat = 7'b1111101;
            4'd7:    pat = 7'b0000111;
            4'd8:    pat = 7'b1111111;
            4'd9:    pat = 7'b1101111;
            default: pat = 7'b0000000;
        endcase
        return pat;
    endfunction

    assign clamp_min_d   = (bus.minutes_input > 7'd99) ? 7'd99 : bus.minutes_input;
    assign clamp_sec_d   = (bus.seconds_input > 6'd59) ? 7'd59 : {1'b0, bus.seconds_input};
    assign blink_phase_d = blink_phase_q ^ bus.blink_tick;

    // One shift-add-3 step per channel: correct both BCD nibbles, then shift the whole word left.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dab
            logic [3:0] ones_adj;
            logic [3:0] tens_adj;
            assign ones_adj  = (sh_q[gi][10:7]  >= 4'd5) ? sh_q[gi][10:7]  + 4'd3 : sh_q[gi][10:7];
            assign tens_adj  = (sh_q[gi][14:11] >= 4'd5) ? sh_q[gi][14:11] + 4'd3 : sh_q[gi][14:11];
            assign dab_d[gi] = {tens_adj[2:0], ones_adj, sh_q[gi][6:0], 1'b0};
        end
    endgenerate

    // The blank decision looks at the post-toggle blink phase so a coincident blink_tick takes effect now.
    always_comb begin
        cur_digit_d = disp_q[digit_idx_q];
        blank_d     = bus.adj && blink_phase_d &&
                      (bus.sel ? !digit_idx_q[1] : digit_idx_q[1]);
`ifdef STOPWATCH_LEADING_ZERO_BLANK_EN
        if (digit_idx_q == 2'd3 && cur_digit_d == 4'd0) begin
            blank_d = 1'b1;
        end
`endif
        seg_d = blank_d ? 7'b0000000 : decode(cur_digit_d);
        if (SEG_ACTIVE_LOW) begin
            seg_d = ~seg_d;
        end
        an_d = 4'b0001 << digit_idx_q;
        if (AN_ACTIVE_LOW) begin
            an_d = ~an_d;
        end
    end

    always_ff @(posedge magic_clk) begin
        if (reset) begin
            state_q       <= IDLE;
            digit_idx_q   <= 2'd3;
            blink_phase_q <= 1'b0;
            conv_busy_q   <= 1'b0;
            an_q          <= AN_OFF;
            seg_q         <= SEG_OFF;
            shift_cnt_q   <= 3'd0;
            for (int i = 0; i < 2; i++) begin
                snap_q[i] <= 7'd0;
                sh_q[i]   <= 15'd0;
            end
            for (int i = 0; i < 4; i++) begin
                disp_q[i] <= 4'd0;
            end
        end else begin
            blink_phase_q <= blink_phase_d;
            if (bus.scan_tick) begin
                digit_idx_q <= digit_idx_q - 2'd1;
                an_q        <= an_d;
                seg_q       <= seg_d;
            end
            case (state_q)
                IDLE: begin
                    // Frame wrap while idle takes the snapshot; a wrap during conversion is dropped.
                    if (bus.scan_tick && digit_idx_q == 2'd0) begin
                        snap_q[0]   <= clamp_sec_d;
                        snap_q[1]   <= clamp_min_d;
                        conv_busy_q <= 1'b1;
                        state_q     <= LOAD;
                    end
                end
                LOAD: begin
                    sh_q[0]     <= {8'd0, snap_q[0]};
                    sh_q[1]     <= {8'd0, snap_q[1]};
                    shift_cnt_q <= 3'd0;
                    state_q     <= SHIFT;
                end
                SHIFT: begin
                    sh_q[0]     <= dab_d[0];
                    sh_q[1]     <= dab_d[1];
                    shift_cnt_q <= shift_cnt_q + 3'd1;
                    if (shift_cnt_q == 3'd6) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    disp_q[3]   <= sh_q[1][14:11];
                    disp_q[2]   <= sh_q[1][10:7];
                    disp_q[1]   <= sh_q[0][14:11];
                    disp_q[0]   <= sh_q[0][10:7];
                    conv_busy_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.seg       = seg_q;
    assign bus.an        = an_q;
    assign bus.conv_busy = conv_busy_q;

endmodule
